// File: rtl/rr_serial_alu.sv
// Bit-serial add/subtract/pass/negate stage producing a double-sign result in rr.
// One full adder plus carry flop; rr, ovf and done update together on the final step.
module rr_serial_alu #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N:0]   rr,
  output logic         busy,
  output logic         done,
  output logic         ovf
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N:0]    sa;
  logic [N:0]    sb;
  logic [N-1:0]  sr;
  logic          carry;
  logic          inv;

  logic [N:0]    ext_a;
  logic [N:0]    ext_b;
  logic          b_bit;
  logic          sum;
  logic          cout;
  logic [N:0]    result;

  always_comb begin
    ext_a  = {a[N-1], a};
    ext_b  = {b[N-1], b};
    b_bit  = sb[0] ^ inv;
    sum    = sa[0] ^ b_bit ^ carry;
    cout   = (sa[0] & b_bit) | (sa[0] & carry) | (b_bit & carry);
    // final sum bit becomes the upper sign bit; sr already holds bits N-1..0
    result = {sum, sr};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      carry <= 1'b0;
      inv   <= 1'b0;
      rr    <= '0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            unique case (op)
              2'b10: begin
                sa <= ext_a;
                sb <= '0;
              end
              2'b11: begin
                sa <= '0;
                sb <= ext_a;
              end
              default: begin
                sa <= ext_a;
                sb <= ext_b;
              end
            endcase
            inv   <= op[0];
            carry <= op[0];
            sr    <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sa    <= {1'b0, sa[N:1]};
          sb    <= {1'b0, sb[N:1]};
          carry <= cout;
          cnt   <= cnt + 1'b1;
          if (N > 1) sr <= {sum, sr[N-1:1]};
          else       sr <= sum;
          if (cnt == LAST) begin
            rr    <= result;
            ovf   <= result[N] ^ result[N-1];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_serial_alu.sv
// Self-checking bench for rr_serial_alu: directed cases, random ops against an
// integer reference model, start-while-busy, back-to-back and mid-op reset.
module tb_rr_serial_alu;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N:0]   rr;
  logic         busy;
  logic         done;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  rr_serial_alu #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .rr    (rr),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  function automatic int sval(input logic [N-1:0] v);
    return int'(v) - (v[N-1] ? (1 << N) : 0);
  endfunction

  function automatic int model_val(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
    case (o)
      2'b00:   return sval(x) + sval(y);
      2'b01:   return sval(x) - sval(y);
      2'b10:   return sval(x);
      default: return -sval(x);
    endcase
  endfunction

  function automatic logic [N:0] model_rr(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
    int r;
    r = model_val(o, x, y);
    return (N+1)'(r & ((1 << (N+1)) - 1));
  endfunction

  function automatic logic model_ovf(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
    int r;
    r = model_val(o, x, y);
    return (r < -(1 << (N-1))) || (r > (1 << (N-1)) - 1);
  endfunction

  // Runs one operation with full cycle-accurate checks; scrambles inputs while busy.
  task automatic run_op(input string name, input logic [1:0] o, input logic [N-1:0] x,
                        input logic [N-1:0] y);
    logic [N:0] err;
    logic       eovf;
    err  = model_rr(o, x, y);
    eovf = model_ovf(o, x, y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    for (int i = 1; i <= N + 1; i++) begin
      @(negedge clk);
      start = 1'b0;
      op = 2'($urandom); a = N'($urandom); b = N'($urandom);
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL %s busy/done cycle %0d: got busy=%b done=%b want busy=1 done=0", name, i, busy, done);
      end
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || rr !== err || ovf !== eovf) begin
      bad++;
      $display("FAIL %s result: got done=%b busy=%b rr=%b ovf=%b want done=1 busy=0 rr=%b ovf=%b",
               name, done, busy, rr, ovf, err, eovf);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || rr !== err || ovf !== eovf) begin
      bad++;
      $display("FAIL %s hold: got done=%b rr=%b ovf=%b want done=0 rr=%b ovf=%b", name, done, rr, ovf, err, eovf);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(negedge clk);
    total++;
    if (rr !== '0 || ovf !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset: got rr=%b ovf=%b busy=%b done=%b want all 0", rr, ovf, busy, done);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_op("add_3_2", 2'b00, 4'b0011, 4'b0010);
    total++;
    if (rr !== 5'b00101) begin bad++; $display("FAIL add_3_2 const: got %b want 00101", rr); end
    run_op("add_5_6", 2'b00, 4'b0101, 4'b0110);
    total++;
    if (rr !== 5'b01011 || ovf !== 1'b1) begin bad++; $display("FAIL add_5_6 const: got rr=%b ovf=%b want 01011 1", rr, ovf); end
    run_op("sub_2_5", 2'b01, 4'b0010, 4'b0101);
    total++;
    if (rr !== 5'b11101 || ovf !== 1'b0) begin bad++; $display("FAIL sub_2_5 const: got rr=%b ovf=%b want 11101 0", rr, ovf); end
    run_op("sub_4_4", 2'b01, 4'b0100, 4'b0100);
    total++;
    if (rr !== 5'b00000) begin bad++; $display("FAIL sub_4_4 const: got %b want 00000", rr); end
    run_op("neg_m8", 2'b11, 4'b1000, 4'b0101);
    total++;
    if (rr !== 5'b01000 || ovf !== 1'b1) begin bad++; $display("FAIL neg_m8 const: got rr=%b ovf=%b want 01000 1", rr, ovf); end
    run_op("pass_7", 2'b10, 4'b0111, 4'b1001);
    total++;
    if (rr !== 5'b00111 || ovf !== 1'b0) begin bad++; $display("FAIL pass_7 const: got rr=%b ovf=%b want 00111 0", rr, ovf); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++)
      run_op("random", 2'($urandom), N'($urandom), N'($urandom));
  endtask

  task automatic test_start_ignored();
    int ndone = 0;
    int dcyc  = -1;
    logic [N:0] err;
    err = model_rr(2'b00, 4'b0001, 4'b0110);
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 4'b0001; b = 4'b0110;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      start = (c == 3);
      if (c == 3) begin op = 2'b01; a = 4'b1111; b = 4'b0011; end
      if (done === 1'b1) begin ndone++; dcyc = c; end
    end
    total++;
    if (ndone != 1 || dcyc != N + 2 || rr !== err) begin
      bad++;
      $display("FAIL start_ignored: got dones=%0d at cycle %0d rr=%b want 1 at %0d rr=%b", ndone, dcyc, rr, N + 2, err);
    end
  endtask

  task automatic test_back_to_back();
    logic [N:0] e1;
    logic [N:0] e2;
    int d1 = -1;
    int d2 = -1;
    int nd = 0;
    e1 = model_rr(2'b01, 4'b0110, 4'b1101);
    e2 = model_rr(2'b11, 4'b0011, 4'b0000);
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 4'b0110; b = 4'b1101;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 1) begin op = 2'b11; a = 4'b0011; b = 4'b0000; end
      if (c == 7) start = 1'b0;
      if (done === 1'b1) begin
        nd++;
        if (nd == 1) begin
          d1 = c;
          total++;
          if (rr !== e1) begin bad++; $display("FAIL b2b first rr: got %b want %b", rr, e1); end
        end else begin
          d2 = c;
          total++;
          if (rr !== e2) begin bad++; $display("FAIL b2b second rr: got %b want %b", rr, e2); end
        end
      end
      if (done === 1'b1 && busy === 1'b1) begin
        total++; bad++;
        $display("FAIL b2b busy_and_done: got both high at cycle %0d want exclusive", c);
      end
    end
    total++;
    if (nd != 2 || d1 != 6 || d2 != 12) begin
      bad++;
      $display("FAIL b2b timing: got %0d dones at %0d,%0d want 2 at 6,12", nd, d1, d2);
    end
  endtask

  task automatic test_reset_midop();
    int nd = 0;
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 4'b0111; b = 4'b0111;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || rr !== '0 || ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_midop: got busy=%b rr=%b ovf=%b want 0 0 0", busy, rr, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    total++;
    if (nd != 0) begin bad++; $display("FAIL reset_midop no_done: got %0d dones want 0", nd); end
    run_op("after_reset_1_1", 2'b00, 4'b0001, 4'b0001);
    total++;
    if (rr !== 5'b00010) begin bad++; $display("FAIL after_reset const: got %b want 00010", rr); end
  endtask

  initial begin
    test_reset();
    test_directed();
    run_op("pre_reset_nonzero", 2'b00, 4'b0101, 4'b0110);
    test_reset_midop();
    test_start_ignored();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
